// File: rtl/wrf_udp_tx_if.sv
// rtl/wrf_udp_tx_if.sv - White Rabbit 16-bit pipelined Wishbone fabric sink bus
interface wrf_udp_tx_if;
  logic [1:0]  adr;
  logic [15:0] dat;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [1:0]  sel;
  logic        ack;
  logic        stall;

  modport master (output adr, dat, cyc, stb, we, sel, input ack, stall);
  modport slave  (input adr, dat, cyc, stb, we, sel, output ack, stall);
endinterface

// File: rtl/wrf_udp_tx.sv
// rtl/wrf_udp_tx.sv - UDP/IPv4 frame transmitter onto the WR fabric sink bus
// Optional internal payload counter: WRF_UDP_TEST_PATTERN_EN
module wrf_udp_tx #(
  parameter int          PAYLOAD_WORDS = 104,
  parameter logic [15:0] STATUS        = 16'h0200,
  parameter logic [47:0] DST_MAC       = 48'h74563c4f4c6d,
  parameter logic [31:0] SRC_IP        = 32'hc0a80105,
  parameter logic [31:0] DST_IP        = 32'hc0a80179,
  parameter logic [15:0] SRC_PORT      = 16'h1000,
  parameter logic [15:0] DST_PORT      = 16'h1000,
  parameter logic [7:0]  TTL           = 8'h3F
) (
  input  logic         wr_sys_clk,
  input  logic         wr_sys_rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [15:0]  frame_id,
  input  logic [15:0]  pl_dat,
  input  logic         pl_valid,
  output logic         pl_ready,
  wrf_udp_tx_if.master wrf_snk
);
  localparam int          N       = 22 + PAYLOAD_WORDS;
  localparam logic [9:0]  LAST    = 10'(N - 1);
  localparam logic [15:0] UDPLEN  = 16'(8 + 2 * PAYLOAD_WORDS);
  localparam logic [15:0] IPLEN   = 16'(28 + 2 * PAYLOAD_WORDS);
  // Constant part of the IPv4 header sum; only the identification varies per frame
  localparam logic [19:0] HDR_SUM = 20'(16'h4500) + 20'(IPLEN) + 20'({TTL, 8'h11})
                                  + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0])
                                  + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_HDR, S_PAY, S_DRAIN} state_t;

  state_t      state;
  logic [9:0]  widx;
  logic [10:0] out_cnt;
  logic [10:0] out_nxt;
  logic [15:0] next_id;
  logic [15:0] cksum;
  logic [15:0] hdr_word;
  logic [15:0] pay_word;
  logic        pay_avail;
  logic        load_en;
  logic        accept;
  logic        ack_ok;
  logic [19:0] id_sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  assign load_en     = !wrf_snk.stb || !wrf_snk.stall;
  assign accept      = wrf_snk.stb && !wrf_snk.stall;
  assign ack_ok      = wrf_snk.ack && (out_cnt != 11'd0);
  assign out_nxt     = out_cnt + 11'(accept) - 11'(ack_ok);
  assign wrf_snk.we  = 1'b1;

  assign id_sum = HDR_SUM + 20'(next_id);
  assign fold1  = 17'(id_sum[15:0]) + 17'(id_sum[19:16]);
  assign fold2  = fold1[15:0] + 16'(fold1[16]);

`ifdef WRF_UDP_TEST_PATTERN_EN
  logic unused_pl;
  assign unused_pl = ^{pl_dat, pl_valid};
  assign pay_word  = 16'(widx - 10'd22);
  assign pay_avail = 1'b1;
  assign pl_ready  = 1'b0;
`else
  assign pay_word  = pl_dat;
  assign pay_avail = pl_valid;
  assign pl_ready  = (state == S_PAY) && load_en;
`endif

  always_comb begin
    hdr_word = 16'h0000;
    case (widx)
      10'd1:  hdr_word = DST_MAC[47:32];
      10'd2:  hdr_word = DST_MAC[31:16];
      10'd3:  hdr_word = DST_MAC[15:0];
      10'd7:  hdr_word = 16'h0800;
      10'd8:  hdr_word = 16'h4500;
      10'd9:  hdr_word = IPLEN;
      10'd10: hdr_word = frame_id;
      10'd12: hdr_word = {TTL, 8'h11};
      10'd13: hdr_word = cksum;
      10'd14: hdr_word = SRC_IP[31:16];
      10'd15: hdr_word = SRC_IP[15:0];
      10'd16: hdr_word = DST_IP[31:16];
      10'd17: hdr_word = DST_IP[15:0];
      10'd18: hdr_word = SRC_PORT;
      10'd19: hdr_word = DST_PORT;
      10'd20: hdr_word = UDPLEN;
      default: hdr_word = 16'h0000;
    endcase
  end

  always_ff @(posedge wr_sys_clk) begin
    if (wr_sys_rst) begin
      state       <= S_IDLE;
      widx        <= 10'd0;
      out_cnt     <= 11'd0;
      next_id     <= 16'd0;
      frame_id    <= 16'd0;
      cksum       <= 16'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wrf_snk.adr <= 2'd0;
      wrf_snk.dat <= 16'd0;
      wrf_snk.cyc <= 1'b0;
      wrf_snk.stb <= 1'b0;
      wrf_snk.sel <= 2'b00;
    end else begin
      done    <= 1'b0;
      out_cnt <= out_nxt;
      case (state)
        S_IDLE: if (start) begin
          frame_id <= next_id;
          next_id  <= next_id + 16'd1;
          cksum    <= ~fold2;
          busy     <= 1'b1;
          state    <= S_CALC;
        end
        S_CALC: begin
          wrf_snk.stb <= 1'b1;
          wrf_snk.cyc <= 1'b1;
          wrf_snk.sel <= 2'b11;
          wrf_snk.adr <= 2'd2;
          wrf_snk.dat <= STATUS;
          widx        <= 10'd1;
          state       <= S_HDR;
        end
        S_HDR: if (load_en) begin
          wrf_snk.adr <= 2'd0;
          wrf_snk.dat <= hdr_word;
          widx        <= widx + 10'd1;
          if (widx == 10'd21) state <= S_PAY;
        end
        S_PAY: if (load_en) begin
          // A missing payload word opens a gap in stb while the cycle stays open
          if (pay_avail) begin
            wrf_snk.stb <= 1'b1;
            wrf_snk.sel <= 2'b11;
            wrf_snk.adr <= 2'd0;
            wrf_snk.dat <= pay_word;
            widx        <= widx + 10'd1;
            if (widx == LAST) state <= S_DRAIN;
          end else begin
            wrf_snk.stb <= 1'b0;
            wrf_snk.sel <= 2'b00;
          end
        end
        S_DRAIN: begin
          if (accept) begin
            wrf_snk.stb <= 1'b0;
            wrf_snk.sel <= 2'b00;
          end
          if (!wrf_snk.stb && out_nxt == 11'd0) begin
            wrf_snk.cyc <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
